// File: rtl/branch_pkg.sv
// Shared types and constants for the branch/jump resolution controller.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    RUN        = 1'b0,
    REDIR_PEND = 1'b1
  } br_state_t;

endpackage

// File: rtl/branch_ctrl_if.sv
// Bundle of EX-stage, fetch and pipeline-register control signals around branch_ctrl.
// master: pipeline side (drives EX/ID info and if_ready); slave: the controller.
interface branch_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             ex_valid;
  logic             ex_branch;
  logic             ex_jump;
  logic [2:0]       ex_funct3;
  logic             ex_zero;
  logic             ex_pos;
  logic             ex_ltu;
  logic [XLEN-1:0]  ex_target;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs2;
  logic             if_ready;
  logic             pc_sel;
  logic [XLEN-1:0]  pc_target;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             br_taken;
  logic             redirect_busy;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ex_valid, ex_branch, ex_jump, ex_funct3, ex_zero, ex_pos, ex_ltu,
           ex_target, ex_mem_read, ex_rd, id_rs1, id_rs2, id_use_rs2, if_ready,
    input  pc_sel, pc_target, pc_write, if_id_write, if_id_flush, id_ex_flush,
           br_taken, redirect_busy, br_cnt, taken_cnt, stall_cnt
  );

  modport slave (
    input  ex_valid, ex_branch, ex_jump, ex_funct3, ex_zero, ex_pos, ex_ltu,
           ex_target, ex_mem_read, ex_rd, id_rs1, id_rs2, id_use_rs2, if_ready,
    output pc_sel, pc_target, pc_write, if_id_write, if_id_flush, id_ex_flush,
           br_taken, redirect_busy, br_cnt, taken_cnt, stall_cnt
  );
endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition: funct3 plus ALU compare flags -> taken condition.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       pos,
  input  logic       ltu,
  output logic       cond
);

  // Decode funct3; 010/011 are not branch encodings and never take.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zero;
      F3_BNE:  cond = ~zero;
      F3_BLT:  cond = ~pos & ~zero;
      F3_BGE:  cond = pos | zero;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump resolution and pipeline-control sequencer.
// Optional statistics counters are built when BRANCH_STATS_EN is defined;
// otherwise the counter ports read as 0.
//
// state      | meaning
// RUN        | normal flow; redirect/flush/stall decided combinationally this cycle
// REDIR_PEND | taken redirect not yet accepted by fetch; hold pend_target, flush all
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  branch_ctrl_if.slave  bus
);

  br_state_t       state;
  logic [XLEN-1:0] pend_target;
  logic            cond;
  logic            taken_run;
  logic            lu_haz;

  branch_cond u_cond (
    .funct3 (bus.ex_funct3),
    .zero   (bus.ex_zero),
    .pos    (bus.ex_pos),
    .ltu    (bus.ex_ltu),
    .cond   (cond)
  );

  assign taken_run = bus.ex_valid & (bus.ex_jump | (bus.ex_branch & cond));
  assign lu_haz    = bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                     ((bus.ex_rd == bus.id_rs1) |
                      (bus.id_use_rs2 & (bus.ex_rd == bus.id_rs2)));

  // Output decode; reset forces the quiet values since RUN outputs are Mealy.
  // A redirect wins over a load-use stall: the stalled instruction is wrong-path.
  always_comb begin
    bus.pc_sel        = 1'b0;
    bus.pc_target     = '0;
    bus.pc_write      = 1'b1;
    bus.if_id_write   = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_flush   = 1'b0;
    bus.br_taken      = 1'b0;
    bus.redirect_busy = 1'b0;
    if (rst_n) begin
      if (state == RUN) begin
        bus.pc_sel      = taken_run;
        bus.pc_target   = bus.ex_target;
        bus.if_id_flush = taken_run;
        bus.id_ex_flush = taken_run | lu_haz;
        bus.pc_write    = taken_run | ~lu_haz;
        bus.if_id_write = taken_run | ~lu_haz;
        bus.br_taken    = taken_run;
      end else begin
        bus.pc_sel        = 1'b1;
        bus.pc_target     = pend_target;
        bus.if_id_flush   = 1'b1;
        bus.id_ex_flush   = 1'b1;
        bus.redirect_busy = 1'b1;
      end
    end
  end

  // Redirect FSM: hold the target until fetch accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pend_target <= '0;
    end else begin
      case (state)
        RUN: begin
          if (taken_run && !bus.if_ready) begin
            pend_target <= bus.ex_target;
            state       <= REDIR_PEND;
          end
        end
        REDIR_PEND: begin
          if (bus.if_ready) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             in_run;

  assign in_run = (state == RUN);

  // Free-running statistics, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (in_run && bus.ex_valid && (bus.ex_branch || bus.ex_jump))
        br_cnt_q <= br_cnt_q + 1'b1;
      if (in_run && taken_run)
        taken_cnt_q <= taken_cnt_q + 1'b1;
      if (in_run && lu_haz && !taken_run)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.br_cnt    = br_cnt_q;
  assign bus.taken_cnt = taken_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.br_cnt    = '0;
  assign bus.taken_cnt = '0;
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: each step drives EX/ID/fetch inputs,
// queues the expected control outputs, and compares them mid-cycle.
module tb_branch_ctrl;
  import branch_pkg::*;

  logic clk;
  logic rst_n;

  branch_ctrl_if #(.XLEN(32), .CNT_W(32)) bus ();

  branch_ctrl #(.XLEN(32), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        branch;
    logic        jump;
    logic [2:0]  f3;
    logic        zero;
    logic        pos;
    logic        ltu;
    logic [31:0] target;
    logic        mem_read;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use_rs2;
    logic        ready;
  } stim_t;

  typedef struct {
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        br_taken;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic stim_t idle(input logic [31:0] tgt, input logic rdy);
    stim_t s;
    s = '{rst: 1'b1, valid: 1'b0, branch: 1'b0, jump: 1'b0, f3: 3'b000, zero: 1'b0,
          pos: 1'b0, ltu: 1'b0, target: tgt, mem_read: 1'b0, rd: 5'd0, rs1: 5'd0,
          rs2: 5'd0, use_rs2: 1'b0, ready: rdy};
    return s;
  endfunction

  function automatic stim_t br(input logic [2:0] f3, input logic z, input logic p,
                               input logic l, input logic [31:0] tgt, input logic rdy);
    stim_t s;
    s = idle(tgt, rdy);
    s.valid = 1'b1; s.branch = 1'b1; s.f3 = f3; s.zero = z; s.pos = p; s.ltu = l;
    return s;
  endfunction

  function automatic stim_t jmp(input logic [31:0] tgt, input logic rdy);
    stim_t s;
    s = idle(tgt, rdy);
    s.valid = 1'b1; s.jump = 1'b1;
    return s;
  endfunction

  function automatic stim_t ld(input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic use2);
    stim_t s;
    s = idle(32'h0, 1'b1);
    s.valid = 1'b1; s.mem_read = 1'b1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.use_rs2 = use2;
    return s;
  endfunction

  // Expected outputs in RUN given whether the step is a taken redirect and/or a load-use hazard.
  function automatic exp_t e_run(input logic taken, input logic haz, input logic [31:0] tgt);
    exp_t e;
    e = '{pc_sel: taken, pc_target: tgt, pc_write: taken | ~haz, if_id_write: taken | ~haz,
          if_id_flush: taken, id_ex_flush: taken | haz, br_taken: taken, busy: 1'b0};
    return e;
  endfunction

  function automatic exp_t e_pend(input logic [31:0] tgt);
    exp_t e;
    e = '{pc_sel: 1'b1, pc_target: tgt, pc_write: 1'b1, if_id_write: 1'b1,
          if_id_flush: 1'b1, id_ex_flush: 1'b1, br_taken: 1'b0, busy: 1'b1};
    return e;
  endfunction

  function automatic exp_t e_rst();
    exp_t e;
    e = '{pc_sel: 1'b0, pc_target: 32'h0, pc_write: 1'b1, if_id_write: 1'b1,
          if_id_flush: 1'b0, id_ex_flush: 1'b0, br_taken: 1'b0, busy: 1'b0};
    return e;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
  task automatic step(input string name, input stim_t s, input exp_t e);
    exp_t x;
    rst_n           = s.rst;
    bus.ex_valid    = s.valid;
    bus.ex_branch   = s.branch;
    bus.ex_jump     = s.jump;
    bus.ex_funct3   = s.f3;
    bus.ex_zero     = s.zero;
    bus.ex_pos      = s.pos;
    bus.ex_ltu      = s.ltu;
    bus.ex_target   = s.target;
    bus.ex_mem_read = s.mem_read;
    bus.ex_rd       = s.rd;
    bus.id_rs1      = s.rs1;
    bus.id_rs2      = s.rs2;
    bus.id_use_rs2  = s.use_rs2;
    bus.if_ready    = s.ready;
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    check_val({name, ".pc_sel"},      64'(bus.pc_sel),        64'(x.pc_sel));
    check_val({name, ".pc_target"},   64'(bus.pc_target),     64'(x.pc_target));
    check_val({name, ".pc_write"},    64'(bus.pc_write),      64'(x.pc_write));
    check_val({name, ".if_id_write"}, 64'(bus.if_id_write),   64'(x.if_id_write));
    check_val({name, ".if_id_flush"}, 64'(bus.if_id_flush),   64'(x.if_id_flush));
    check_val({name, ".id_ex_flush"}, 64'(bus.id_ex_flush),   64'(x.id_ex_flush));
    check_val({name, ".br_taken"},    64'(bus.br_taken),      64'(x.br_taken));
    check_val({name, ".busy"},        64'(bus.redirect_busy), 64'(x.busy));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] f3;
    logic       z;
    logic       p;
    logic       l;
    logic       taken;
  } cond_t;

  cond_t ctab[$];

  initial begin
    stim_t s;
    logic [31:0] exp_br, exp_tk, exp_st;
    n_cmp = 0;
    n_err = 0;

    s = br(F3_BEQ, 1'b1, 1'b0, 1'b0, 32'h55, 1'b1);
    s.rst = 1'b0;
    rst_n = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_branch = 1'b0; bus.ex_jump = 1'b0; bus.ex_funct3 = 3'b0;
    bus.ex_zero = 1'b0; bus.ex_pos = 1'b0; bus.ex_ltu = 1'b0; bus.ex_target = 32'h0;
    bus.ex_mem_read = 1'b0; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    bus.id_use_rs2 = 1'b0; bus.if_ready = 1'b1;
    @(posedge clk);
    #1;
    step("reset", s, e_rst());
    check_val("reset.br_cnt", 64'(bus.br_cnt), 64'd0);
    check_val("reset.taken_cnt", 64'(bus.taken_cnt), 64'd0);

    // beq taken, fetch ready: same-cycle redirect, stays in RUN
    step("beq_taken", br(F3_BEQ, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1), e_run(1'b1, 1'b0, 32'h100));
    step("after_beq", idle(32'h104, 1'b1), e_run(1'b0, 1'b0, 32'h104));

    // condition decode table
    ctab = '{
      '{F3_BEQ,  1'b0, 1'b0, 1'b0, 1'b0},
      '{F3_BNE,  1'b0, 1'b0, 1'b0, 1'b1},
      '{F3_BNE,  1'b1, 1'b0, 1'b0, 1'b0},
      '{F3_BLT,  1'b0, 1'b0, 1'b0, 1'b1},
      '{F3_BLT,  1'b0, 1'b1, 1'b0, 1'b0},
      '{F3_BLT,  1'b1, 1'b0, 1'b0, 1'b0},
      '{F3_BGE,  1'b0, 1'b0, 1'b0, 1'b0},
      '{F3_BGE,  1'b1, 1'b0, 1'b0, 1'b1},
      '{F3_BGE,  1'b0, 1'b1, 1'b0, 1'b1},
      '{F3_BLTU, 1'b0, 1'b0, 1'b1, 1'b1},
      '{F3_BLTU, 1'b0, 1'b0, 1'b0, 1'b0},
      '{F3_BGEU, 1'b0, 1'b0, 1'b0, 1'b1},
      '{F3_BGEU, 1'b0, 1'b0, 1'b1, 1'b0},
      '{3'b010,  1'b1, 1'b1, 1'b1, 1'b0},
      '{3'b011,  1'b1, 1'b0, 1'b1, 1'b0}
    };
    for (int i = 0; i < ctab.size(); i++) begin
      step($sformatf("cond%0d", i),
           br(ctab[i].f3, ctab[i].z, ctab[i].p, ctab[i].l, 32'h400 + 32'(i * 4), 1'b1),
           e_run(ctab[i].taken, 1'b0, 32'h400 + 32'(i * 4)));
    end

    // load-use stall lasts exactly one cycle; x0 never stalls; rs2 only when used
    step("lu_rs1", ld(5'd5, 5'd5, 5'd0, 1'b0), e_run(1'b0, 1'b1, 32'h0));
    step("lu_after", idle(32'h0, 1'b1), e_run(1'b0, 1'b0, 32'h0));
    step("lu_x0", ld(5'd0, 5'd0, 5'd0, 1'b1), e_run(1'b0, 1'b0, 32'h0));
    step("lu_rs2", ld(5'd9, 5'd1, 5'd9, 1'b1), e_run(1'b0, 1'b1, 32'h0));
    step("lu_rs2_unused", ld(5'd9, 5'd1, 5'd9, 1'b0), e_run(1'b0, 1'b0, 32'h0));
    s = ld(5'd5, 5'd5, 5'd0, 1'b0);
    s.valid = 1'b0;
    step("lu_invalid", s, e_run(1'b0, 1'b0, 32'h0));

    // jal with fetch stalled: pending target held while EX inputs churn
    step("jal_stall", jmp(32'h200, 1'b0), e_run(1'b1, 1'b0, 32'h200));
    step("pend1", jmp(32'h2A0, 1'b0), e_pend(32'h200));
    step("pend2", br(F3_BEQ, 1'b1, 1'b0, 1'b0, 32'h2B0, 1'b0), e_pend(32'h200));
    step("pend3", idle(32'h2C0, 1'b1), e_pend(32'h200));
    step("pend_exit", idle(32'h2D0, 1'b0), e_run(1'b0, 1'b0, 32'h2D0));

    // redirect beats load-use stall
    s = ld(5'd6, 5'd6, 5'd0, 1'b0);
    s.branch = 1'b1; s.f3 = F3_BEQ; s.zero = 1'b1; s.target = 32'h500;
    step("lu_vs_br", s, e_run(1'b1, 1'b1, 32'h500));

    // reset in REDIR_PEND drops the pending redirect
    step("jal_rst", jmp(32'h300, 1'b0), e_run(1'b1, 1'b0, 32'h300));
    step("pend_rst", idle(32'h310, 1'b0), e_pend(32'h300));
    s = jmp(32'h320, 1'b0);
    s.rst = 1'b0;
    step("mid_rst", s, e_rst());
    step("post_rst", idle(32'h330, 1'b0), e_run(1'b0, 1'b0, 32'h330));

    // statistics: 4 branches (2 taken) and 1 stall since the last reset
    step("st_beq", br(F3_BEQ, 1'b1, 1'b0, 1'b0, 32'h600, 1'b1), e_run(1'b1, 1'b0, 32'h600));
    step("st_bne", br(F3_BNE, 1'b1, 1'b0, 1'b0, 32'h604, 1'b1), e_run(1'b0, 1'b0, 32'h604));
    step("st_jal", jmp(32'h608, 1'b1), e_run(1'b1, 1'b0, 32'h608));
    step("st_bltu", br(F3_BLTU, 1'b0, 1'b0, 1'b0, 32'h60C, 1'b1), e_run(1'b0, 1'b0, 32'h60C));
    step("st_lu", ld(5'd7, 5'd7, 5'd0, 1'b0), e_run(1'b0, 1'b1, 32'h0));
    step("st_idle", idle(32'h0, 1'b1), e_run(1'b0, 1'b0, 32'h0));
`ifdef BRANCH_STATS_EN
    exp_br = 32'd4; exp_tk = 32'd2; exp_st = 32'd1;
`else
    exp_br = 32'd0; exp_tk = 32'd0; exp_st = 32'd0;
`endif
    check_val("br_cnt", 64'(bus.br_cnt), 64'(exp_br));
    check_val("taken_cnt", 64'(bus.taken_cnt), 64'(exp_tk));
    check_val("stall_cnt", 64'(bus.stall_cnt), 64'(exp_st));
    check_val("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
